// File: rtl/ins_mem_loader_if.sv
// Byte-stream receive channel and instruction-memory write port of the boot loader.
interface ins_mem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/ins_mem_loader.sv
// Boot loader: 16-bit length + big-endian words into instruction memory, holds the CPU until done.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module ins_mem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               start,
    ins_mem_loader_if.slave    bus,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output logic [15:0]        words_loaded
);
    // state  | meaning
    // IDLE   | after reset, waiting for start
    // LEN_HI | expecting length MSB
    // LEN_LO | expecting length LSB, range check
    // DATA   | collecting the 4 bytes of a word
    // WRITE  | one-cycle memory write strobe
    // CSUM   | expecting XOR checksum byte (checksum build only)
    // DONE   | image loaded, CPU released
    // ERR    | load failed, CPU held
    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, WRITE,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE, ERR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t FIN = CSUM;
`else
    localparam state_t FIN = DONE;
`endif
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    state_t              state, state_next;
    logic                accept, launch, ready_next;
    logic [15:0]         len, len_new;
    logic [1:0]          byte_cnt;
    logic [23:0]         word;
    logic [ADDR_W-1:0]   idx;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    assign accept  = bus.rx_valid && bus.rx_ready;
    assign launch  = start && (state == IDLE || state == DONE || state == ERR);
    assign len_new = {len[7:0], bus.rx_data};

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_next = LEN_HI;
            LEN_HI:          if (accept) state_next = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (len_new == 16'd0)                   state_next = FIN;
                    else if ({1'b0, len_new} > MAX_WORDS)   state_next = ERR;
                    else                                    state_next = DATA;
                end
            end
            DATA:   if (accept && byte_cnt == 2'd3) state_next = WRITE;
            WRITE:  state_next = (words_loaded + 16'd1 == len) ? FIN : DATA;
`ifdef LOADER_CHECKSUM_EN
            CSUM:   if (accept) state_next = (bus.rx_data == csum) ? DONE : ERR;
`endif
            default: state_next = IDLE;
        endcase

        ready_next = (state_next == LEN_HI) || (state_next == LEN_LO) || (state_next == DATA);
`ifdef LOADER_CHECKSUM_EN
        if (state_next == CSUM) ready_next = 1'b1;
`endif
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state          <= IDLE;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= 32'd0;
            bus.imem_wdata <= 32'd0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            words_loaded   <= 16'd0;
            len            <= 16'd0;
            byte_cnt       <= 2'd0;
            word           <= 24'd0;
            idx            <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum           <= 8'd0;
`endif
        end else begin
            state        <= state_next;
            bus.rx_ready <= ready_next;
            bus.imem_we  <= (state_next == WRITE);
            cpu_hold     <= (state_next != DONE);
            done         <= (state_next == DONE);
            error        <= (state_next == ERR);

            if (state == DATA && state_next == WRITE) begin
                bus.imem_addr  <= {{(30-ADDR_W){1'b0}}, idx, 2'b00};
                bus.imem_wdata <= {word, bus.rx_data};
            end

            if (launch) begin
                words_loaded <= 16'd0;
                len          <= 16'd0;
                byte_cnt     <= 2'd0;
                idx          <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum         <= 8'd0;
`endif
            end

            if (accept && (state == LEN_HI || state == LEN_LO))
                len <= len_new;

            if (accept && state == DATA) begin
                word     <= {word[15:0], bus.rx_data};
                byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum     <= csum ^ bus.rx_data;
`endif
            end

            if (state == WRITE) begin
                idx          <= idx + ADDR_W'(1);
                words_loaded <= words_loaded + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader: default-size instance plus an ADDR_W=4 instance for the length bound.
module tb_ins_mem_loader;
    logic        CLK = 1'b0;
    logic        Reset;
    logic        start, start2;
    logic        hold, done, error, hold2, done2, error2;
    logic [15:0] wl, wl2;

    ins_mem_loader_if bus ();
    ins_mem_loader_if bus2 ();

    ins_mem_loader #(.ADDR_W(8)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .bus(bus),
        .cpu_hold(hold), .done(done), .error(error), .words_loaded(wl)
    );

    ins_mem_loader #(.ADDR_W(4)) dut2 (
        .CLK(CLK), .Reset(Reset), .start(start2), .bus(bus2),
        .cpu_hold(hold2), .done(done2), .error(error2), .words_loaded(wl2)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] wa [64];
    logic [31:0] wd [64];
    logic [31:0] wa2 [64];
    logic [31:0] wd2 [64];
    int wn = 0, wn2 = 0, rdy_viol = 0;

    always @(negedge CLK) begin
        if (bus.imem_we === 1'b1 && wn < 64) begin
            wa[wn] = bus.imem_addr;
            wd[wn] = bus.imem_wdata;
            wn++;
            if (bus.rx_ready !== 1'b0) rdy_viol++;
        end
        if (bus2.imem_we === 1'b1 && wn2 < 64) begin
            wa2[wn2] = bus2.imem_addr;
            wd2[wn2] = bus2.imem_wdata;
            wn2++;
        end
    end

    logic [7:0] img [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int which, input logic [7:0] b);
        logic ok;
        logic accepted;
        accepted = 1'b0;
        if (which == 0) begin bus.rx_valid = 1'b1; bus.rx_data = b; end
        else begin bus2.rx_valid = 1'b1; bus2.rx_data = b; end
        for (int i = 0; i < 50; i++) begin
            ok = (which == 0) ? bus.rx_ready : bus2.rx_ready;
            @(posedge CLK); #1;
            if (ok) begin accepted = 1'b1; break; end
        end
        chk("send_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        bus2.rx_valid = 1'b0;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic pulse_start(input int which);
        if (which == 0) start = 1'b1; else start2 = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        chk({tag, "_we"}, 32'(bus.imem_we), 32'd0);
        chk({tag, "_addr"}, bus.imem_addr, 32'd0);
        chk({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        chk({tag, "_hold"}, 32'(hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_words"}, 32'(wl), 32'd0);
    endtask

    task automatic check_two_writes(input string tag, input int base);
        chk({tag, "_nwr"}, 32'(wn - base), 32'd2);
        chk({tag, "_a0"}, wa[base], 32'h0);
        chk({tag, "_d0"}, wd[base], 32'h20080005);
        chk({tag, "_a1"}, wa[base+1], 32'h4);
        chk({tag, "_d1"}, wd[base+1], 32'h8C090004);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        Reset = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus2.rx_valid = 1'b0;
        bus2.rx_data = 8'h00;
        #3 Reset = 1'b0;
        #10;
        check_reset_values("rst");
        chk("rst_hold2", 32'(hold2), 32'd1);
        @(posedge CLK); #1;
        Reset = 1'b1;
        @(posedge CLK); #1;

        // Scenario 1: back-to-back image, start coincident with a presented byte
        base = wn;
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h00;
        pulse_start(0);
        chk("s1_ready_after_start", 32'(bus.rx_ready), 32'd1);
        chk("s1_words_after_start", 32'(wl), 32'd0);
        for (int k = 0; k < 6; k++) send(0, img[k]);
        chk("s1_we_latency", 32'(bus.imem_we), 32'd1);
        chk("s1_ready_in_write", 32'(bus.rx_ready), 32'd0);
        chk("s1_addr_at_write", bus.imem_addr, 32'h0);
        chk("s1_wdata_at_write", bus.imem_wdata, 32'h20080005);
        for (int k = 6; k < 10; k++) send(0, img[k]);
        chk("s1_done_during_last_write", 32'(done), 32'd0);
        chk("s1_we_last", 32'(bus.imem_we), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        send(0, 8'hAC);
        idle(0);
`else
        idle(1);
`endif
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_hold", 32'(hold), 32'd0);
        chk("s1_words", 32'(wl), 32'd2);
        chk("s1_we_after", 32'(bus.imem_we), 32'd0);
        check_two_writes("s1", base);

        // Scenario 2: empty image
        base = wn;
        pulse_start(0);
        chk("s2_done_cleared", 32'(done), 32'd0);
        chk("s2_hold_set", 32'(hold), 32'd1);
        send(0, 8'h00);
        send(0, 8'h00);
`ifdef LOADER_CHECKSUM_EN
        send(0, 8'h00);
`endif
        idle(0);
        chk("s2_done", 32'(done), 32'd1);
        chk("s2_hold", 32'(hold), 32'd0);
        chk("s2_words", 32'(wl), 32'd0);
        idle(2);
        chk("s2_no_writes", 32'(wn - base), 32'd0);

        // Scenario 3: ADDR_W=4, N=17 rejected, then N=16 (the bound) loads fully
        pulse_start(1);
        send(1, 8'h00);
        send(1, 8'h11);
        idle(1);
        chk("s3_error", 32'(error2), 32'd1);
        chk("s3_hold", 32'(hold2), 32'd1);
        chk("s3_ready", 32'(bus2.rx_ready), 32'd0);
        chk("s3_no_writes", 32'(wn2), 32'd0);
        pulse_start(1);
        chk("s3_error_cleared", 32'(error2), 32'd0);
        send(1, 8'h00);
        send(1, 8'h10);
        chk("s3_bound_ok", 32'(error2), 32'd0);
        chk("s3_bound_ready", 32'(bus2.rx_ready), 32'd1);
        for (int i = 0; i < 64; i++) send(1, 8'(i));
`ifdef LOADER_CHECKSUM_EN
        send(1, 8'h00);
        idle(0);
`else
        idle(1);
`endif
        chk("s3_done", 32'(done2), 32'd1);
        chk("s3_hold_released", 32'(hold2), 32'd0);
        chk("s3_words", 32'(wl2), 32'd16);
        chk("s3_nwr", 32'(wn2), 32'd16);
        chk("s3_a0", wa2[0], 32'h0);
        chk("s3_d0", wd2[0], 32'h00010203);
        chk("s3_a15", wa2[15], 32'h3C);
        chk("s3_d15", wd2[15], 32'h3C3D3E3F);

        // Scenario 4: valid every other cycle, byte held across WRITE, ignored mid-load start
        base = wn;
        rdy_viol = 0;
        pulse_start(0);
        for (int k = 0; k < 10; k++) begin
            send(0, img[k]);
            if (k == 1) begin
                bus.rx_valid = 1'b0;
                pulse_start(0);
            end else if (k != 5) begin
                idle(1);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send(0, 8'hAC);
        idle(0);
`endif
        chk("s4_done", 32'(done), 32'd1);
        chk("s4_words", 32'(wl), 32'd2);
        chk("s4_ready_in_write", 32'(rdy_viol), 32'd0);
        check_two_writes("s4", base);

        // Scenario 5: reset mid-load, then a clean reload
        pulse_start(0);
        for (int k = 0; k < 7; k++) send(0, img[k]);
        bus.rx_valid = 1'b0;
        #3 Reset = 1'b0;
        #1;
        check_reset_values("s5_rst");
        @(posedge CLK); #1;
        Reset = 1'b1;
        base = wn;
        pulse_start(0);
        for (int k = 0; k < 10; k++) send(0, img[k]);
`ifdef LOADER_CHECKSUM_EN
        send(0, 8'hAC);
        idle(0);
`else
        idle(1);
`endif
        chk("s5_done", 32'(done), 32'd1);
        chk("s5_hold", 32'(hold), 32'd0);
        check_two_writes("s5", base);

`ifdef LOADER_CHECKSUM_EN
        // Scenario 6: wrong checksum after both writes
        base = wn;
        pulse_start(0);
        for (int k = 0; k < 10; k++) send(0, img[k]);
        send(0, 8'hAD);
        idle(1);
        chk("s6_error", 32'(error), 32'd1);
        chk("s6_hold", 32'(hold), 32'd1);
        chk("s6_done", 32'(done), 32'd0);
        check_two_writes("s6", base);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
